// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and the bubble/reset encodings used by fetch, decode
// and the ID/FO register.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } if_state_e;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/if_fetch_stage_hold_buffer.sv
// One-entry instruction+pc buffer that parks a fetched word while decode is stalled.
module if_hold_buffer #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // clear wins over load so a redirect can never leave a wrong-path word parked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction memory and
// hands one instruction (or a NOP bubble) per cycle to decode.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEFAULT_NOP_WORD)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out,
  output if_state_e          state_dbg
);

  // Memory handshake: a transfer happens on a cycle with imem_req=1 and imem_ready=1.
  // Once raised, imem_req stays high with imem_addr unchanged until that cycle;
  // imem_ready while imem_req=0 carries no meaning and is never looked at.
  if_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pend_q, pend_d, pc_out_d, pc_inc;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  logic               hb_load, hb_clear, hb_valid;
  logic [INSTR_W-1:0] hb_instr;
  logic [ADDR_W-1:0]  hb_pc;

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = pc_q;
  assign state_dbg = state_q;

  if_hold_buffer #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hb_load),
    .clear    (hb_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .valid    (hb_valid),
    .instr    (hb_instr),
    .pc       (hb_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      instr_out <= NOP_WORD;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      instr_out <= instr_d;
      pc_out    <= pc_out_d;
      valid_out <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    instr_d  = instr_out;
    pc_out_d = pc_out;
    valid_d  = valid_out;
    hb_load  = 1'b0;
    hb_clear = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d     = redirect_pc;
          hb_clear = 1'b1;
          valid_d  = 1'b0;
          instr_d  = NOP_WORD;
        end
      end

      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          if (imem_ready) begin
            pc_d     = redirect_pc;
            hb_clear = 1'b1;
          end else begin
            // request still in flight: let it finish, then jump
            pend_d  = redirect_pc;
            state_d = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (stall) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d     = redirect_pc;
          hb_clear = 1'b1;
          valid_d  = 1'b0;
          instr_d  = NOP_WORD;
          state_d  = FETCH;
        end else if (!stall) begin
          instr_d  = hb_valid ? hb_instr : NOP_WORD;
          pc_out_d = hb_pc;
          valid_d  = hb_valid;
          hb_clear = 1'b1;
          state_d  = FETCH;
        end
      end

      DRAIN: begin
        // outputs are already a bubble here, so forcing NOP also honours stall
        valid_d = 1'b0;
        instr_d = NOP_WORD;
        if (imem_ready) begin
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_d = redirect_pc;
        end
      end

      default: state_d = BOOT;
    endcase
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage at the front of the pipeline; sole producer of the instruction word and PC consumed by the decode stage, which drives the ID/FO register.
- Holds the PC and runs a req/ready handshake with instruction memory.
- Obeys stall from hazard logic and redirect from branch resolution.
- Emits one instruction per cycle with a valid flag. Bubbles are valid=0 with instr=NOP.

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded at reset
NOP_WORD, 0, instruction emitted on bubbles and at reset

Ports:
clk  in  1  rising-edge clock, only clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held with imem_addr stable until imem_ready
imem_addr  out  ADDR_W  word address of request
imem_ready  in  1  response valid this cycle; meaningful only while imem_req=1
imem_rdata  in  INSTR_W  instruction word, valid with imem_ready
stall  in  1  decode cannot accept; hold outputs
redirect  in  1  branch/jump taken; one-cycle pulse
redirect_pc  in  ADDR_W  new PC, valid with redirect
instr_out  out  INSTR_W  instruction to decode
pc_out  out  ADDR_W  address of instr_out
valid_out  out  1  instr_out/pc_out are a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=BOOT; imem_req=0.
  - valid_out=0; instr_out=NOP_WORD; pc_out=0; hold buffer empty.
- States:
  - BOOT: one cycle after rst_n rises, -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. Word captured, waiting for stall to drop.
  - DRAIN: imem_req=1 at the stale address. Response will be discarded.
- FETCH with imem_ready=1, stall=0:
  - Next edge: instr_out=imem_rdata, pc_out=pc, valid_out=1.
  - pc=pc+1, modulo 2^ADDR_W; 0xFFFF wraps to 0x0000.
  - Latency: response to output register is 1 cycle. Throughput is 1/cycle with single-cycle memory.
- FETCH with imem_ready=1, stall=1:
  - Word and its pc go to the hold buffer; pc=pc+1; -> HOLD.
  - Outputs unchanged.
- FETCH with imem_ready=0:
  - stall=0: valid_out=0, instr_out=NOP_WORD (bubble).
  - stall=1: outputs unchanged.
- HOLD:
  - While stall=1, everything is frozen.
  - On the first cycle with stall=0: outputs take the held word, valid_out=1; -> FETCH.
- Any stall=1 cycle: instr_out, pc_out and valid_out keep their previous values exactly.
- redirect has priority over stall and over any capture:
  - No outstanding request (BOOT, HOLD, or FETCH with imem_ready=1 this cycle): pc=redirect_pc, hold buffer cleared, -> FETCH.
  - FETCH with imem_ready=0: latch redirect_pc into pending register; -> DRAIN.
  - DRAIN: when imem_ready=1, discard rdata; pc=pending; -> FETCH.
  - Redirect during DRAIN: overwrites pending; the newest redirect wins.
  - In every redirect case, next edge: valid_out=0, instr_out=NOP_WORD, regardless of stall. Decode must see a bubble, not a wrong-path instruction.
- Handshake rules:
  - imem_req never drops and imem_addr never changes while a request is outstanding (req=1, ready=0).
  - imem_ready with imem_req=0 is ignored.
- rst_n asserted mid-transaction: immediate return to reset values. The memory side must tolerate an abandoned request.
- No X on any output after reset.

Decomposition:
- Package if_pkg holds:
  - the state enum (BOOT, FETCH, HOLD, DRAIN);
  - the default NOP_WORD and RESET_PC constants, shared with decode and the ID/FO register for bubble encoding.
- Sub-module if_hold_buffer: one-entry instruction+pc buffer with load/clear/valid. Everything else stays in one module.

Test Plan:
- Reset, then zero-wait memory returning rdata=addr+0x100, stall=0 -> from the 2nd cycle after reset release, valid_out=1 each cycle with pc_out 0,1,2,3 and instr_out 0x100,0x101,...
- Memory with 2 wait states -> valid_out pattern 0,0,1 repeating; imem_addr stable during the wait; pc_out increments once per instruction.
- stall=1 for 3 cycles while the word at pc 5 returns -> outputs frozen; HOLD entered; imem_req=0. After stall falls: one cycle with pc_out=5, then fetch resumes at 6.
- redirect to 0x40 while a request at 0x07 is outstanding (2 wait states) -> DRAIN; 0x07 data never appears on outputs; valid_out=0; next imem_addr=0x40; pc_out=0x40 follows.
- redirect together with stall=1 in HOLD -> hold buffer cleared; valid_out=0 next cycle; fetch from redirect_pc.
- RESET_PC=0xFFFE with zero-wait memory -> pc_out sequence 0xFFFE,0xFFFF,0x0000. Also: rst_n pulse mid-wait-state returns all outputs to reset values asynchronously.
